// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA ROM scan-out controller.
//  - 640x480@60 timing defaults (VGA_H_*/VGA_V_*, totals)
//  - host read FSM state encoding
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } host_state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and region decode.
// Ports:
//   clk, rst      clock, async active-high reset
//   pix_en        advance one pixel when high
//   vis           current pixel is in the visible region
//   in_img        current pixel is inside the stored image
//   hs_n, vs_n    active-low sync decode for the current pixel
//   first         current pixel is (0,0)
//   frame_last    current pixel is the last of the frame (next is (0,0))
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  output logic vis,
  output logic in_img,
  output logic hs_n,
  output logic vs_n,
  output logic first,
  output logic frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_end;
  logic          v_end;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign vis        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_img     = (h_cnt < H_IMG) && (v_cnt < V_IMG);
  assign hs_n       = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vs_n       = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign first      = (h_cnt == '0) && (v_cnt == '0);
  assign frame_last = h_end && v_end;

endmodule

// File: rtl/vga_rom_fetch_ctrl.sv
// Image ROM scan-out controller: VGA timing, linear ROM address generation,
// alignment of the 1-clk ROM read data with sync/de, and opportunistic host
// reads through the same ROM port whenever the display does not need it.
// Ports:
//   clk, rst                  clock, async active-high reset
//   pix_en                    pixel-rate enable
//   rom_addr / rom_rdata      ROM read port (data returns one clk later)
//   hsync, vsync, de, rgb     registered VGA outputs (2 clk after pix_en)
//   frame_start               1-clk pulse with output pixel (0,0)
//   host_req / host_addr      host read request (level) and address
//   host_ack / host_rdata     1-clk ack pulse and held read data
module vga_rom_fetch_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  frame_start,
  input  logic                  host_req,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata
);

  localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  logic vis, in_img, hs_n, vs_n, first, frame_last;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) u_timing (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .vis(vis), .in_img(in_img), .hs_n(hs_n), .vs_n(vs_n),
    .first(first), .frame_last(frame_last)
  );

  // Linear image address; parks on the last word after the final image pixel
  // so it never leaves the image range before the frame wraps.
  logic [ADDR_WIDTH-1:0] pix_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_addr <= '0;
    end else if (pix_en) begin
      if (frame_last)
        pix_addr <= '0;
      else if (in_img && (pix_addr != PIX_LAST))
        pix_addr <= pix_addr + 1'b1;
    end
  end

  // Stage 1 holds the decode of the pixel whose ROM word arrives next clk.
  logic s1_vis, s1_img, s1_hs_n, s1_vs_n, s1_first, pen_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vis   <= 1'b0;
      s1_img   <= 1'b0;
      s1_hs_n  <= 1'b1;
      s1_vs_n  <= 1'b1;
      s1_first <= 1'b0;
      pen_d    <= 1'b0;
    end else begin
      pen_d <= pix_en;
      if (pix_en) begin
        s1_vis   <= vis;
        s1_img   <= in_img;
        s1_hs_n  <= hs_n;
        s1_vs_n  <= vs_n;
        s1_first <= first;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else if (pen_d) begin
      rgb         <= s1_img ? rom_rdata : (s1_vis ? BG_COLOR : '0);
      de          <= s1_vis;
      hsync       <= s1_hs_n;
      vsync       <= s1_vs_n;
      frame_start <= s1_first;
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Host port: the display owns the ROM whenever it samples an image pixel.
  // req_block forces a low cycle on host_req between transactions so a
  // request held across its ack is not served twice.
  host_state_t state_q, state_d;
  logic        disp_need;
  logic        host_issue;
  logic        req_block;

  assign disp_need = pix_en && in_img;
  assign rom_addr  = host_issue ? host_addr : pix_addr;

  always_comb begin
    state_d    = state_q;
    host_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_req && !req_block && !disp_need) begin
          host_issue = 1'b1;
          state_d    = DATA;
        end
      end
      DATA:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      req_block  <= 1'b0;
    end else begin
      state_q  <= state_d;
      host_ack <= (state_q == DATA);
      if (state_q == DATA) begin
        host_rdata <= rom_rdata;
        req_block  <= 1'b1;
      end else if (!host_req) begin
        req_block  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_rom_fetch_ctrl.sv
module tb_vga_rom_fetch_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int IW = 4, IH = 4;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BG = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [23:0] rom_addr;
  logic [23:0] rom_rdata = '0;
  logic        hsync, vsync, de, frame_start, host_ack;
  logic [23:0] rgb, host_rdata;
  logic        host_req;
  logic [23:0] host_addr;

  always #5 clk = ~clk;

  // 1-clk registered ROM with ROM[a] = a
  always @(posedge clk) rom_rdata <= rom_addr;

  vga_rom_fetch_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH), .DATA_WIDTH(24), .ADDR_WIDTH(24),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .frame_start(frame_start),
    .host_req(host_req), .host_addr(host_addr),
    .host_ack(host_ack), .host_rdata(host_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  int          p;
  logic        m_pen_d;
  logic        s_vis, s_hs, s_vs, s_first;
  logic [23:0] s_rgb;
  logic        e_de, e_hs, e_vs, e_fs;
  logic [23:0] e_rgb, e_rdata, pend_addr;
  int          busy_until, ack_cyc;
  logic        need_low;
  int          fs_count, hs_low_count, de_count, ack_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_de"}, de, 1'b0);
    chk({tag, "_hsync"}, hsync, 1'b1);
    chk({tag, "_vsync"}, vsync, 1'b1);
    chk({tag, "_rgb"}, rgb, 24'h0);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_ack"}, host_ack, 1'b0);
    chk({tag, "_rdata"}, host_rdata, 24'h0);
  endtask

  task automatic model_reset();
    p = 0; m_pen_d = 0;
    s_vis = 0; s_hs = 1; s_vs = 1; s_first = 0; s_rgb = '0;
    e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_rgb = '0; e_rdata = '0;
    busy_until = -10; ack_cyc = -10; need_low = 0; pend_addr = '0;
  endtask

  function automatic logic [23:0] pix_color(input int h, input int v);
    if (h < IW && v < IH) return 24'(v * IW + h);
    else if (h < HA && v < VA) return BG;
    else return 24'h0;
  endfunction

  // One clock: predict from current inputs, advance, compare all outputs.
  task automatic step();
    int   h, v;
    logic img, issue;
    h = p % HT;
    v = p / HT;
    img = (h < IW) && (v < IH);
    if (m_pen_d) begin
      e_de = s_vis; e_hs = s_hs; e_vs = s_vs; e_fs = s_first; e_rgb = s_rgb;
    end else begin
      e_fs = 0;
    end
    m_pen_d = pix_en;
    if (pix_en) begin
      s_vis   = (h < HA) && (v < VA);
      s_hs    = !(h >= HA + HF && h < HA + HF + HS);
      s_vs    = !(v >= VA + VF && v < VA + VF + VS);
      s_first = (p == 0);
      s_rgb   = pix_color(h, v);
      p = (p + 1) % FRAME;
    end
    issue = (cyc > busy_until) && host_req && !need_low && !(pix_en && img);
    if (!host_req && cyc >= busy_until) need_low = 0;
    if (issue) begin
      need_low = 1; busy_until = cyc + 2; ack_cyc = cyc + 2; pend_addr = host_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == ack_cyc) e_rdata = pend_addr;
    chk("de", de, e_de);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("rgb", rgb, e_rgb);
    chk("frame_start", frame_start, e_fs);
    chk("host_ack", host_ack, (cyc == ack_cyc));
    chk("host_rdata", host_rdata, e_rdata);
    if (frame_start) fs_count++;
    if (!hsync) hs_low_count++;
    if (de) de_count++;
    if (host_ack) ack_count++;
  endtask

  initial begin
    int ack_p, n, hold;
    logic got;
    rst = 1'b1; pix_en = 1'b0; host_req = 1'b0; host_addr = '0;
    #2;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // two full frames, free-running pixel clock
    fs_count = 0; hs_low_count = 0; de_count = 0;
    pix_en = 1'b1;
    repeat (2 * FRAME) step();
    chk("fs_count", fs_count, 2);
    chk("hs_low_count", hs_low_count, 2 * VT * HS);
    chk("de_count", de_count, 2 * VA * HA);

    // host request raised inside the image, must wait for h == IW
    step();
    host_req = 1'b1; host_addr = 24'h001234;
    got = 0; ack_p = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (host_ack) begin got = 1; ack_p = p; host_req = 1'b0; end
    end
    chk("host_ack_seen", got, 1'b1);
    chk("host_ack_pos", ack_p, 6);
    chk("host_rdata_1234", host_rdata, 24'h001234);

    // pix_en one clk in four, well-behaved random host
    for (int i = 0; i < 4 * FRAME; i++) begin
      pix_en = (i % 4 == 0);
      step();
      if (host_req && host_ack) host_req = 1'b0;
      else if (!host_req && $urandom_range(3) == 0) begin
        host_req = 1'b1; host_addr = 24'($urandom);
      end
    end
    host_req = 1'b0;
    pix_en = 1'b1;
    step();

    // request held across ack: one ack only, re-served after a low cycle
    pix_en = 1'b0;
    ack_count = 0;
    host_req = 1'b1; host_addr = 24'h00BEEF;
    repeat (8) step();
    chk("held_req_acks", ack_count, 1);
    host_req = 1'b0;
    step();
    host_req = 1'b1; host_addr = 24'h00CAFE;
    ack_count = 0;
    repeat (3) step();
    chk("rearm_acks", ack_count, 1);
    chk("rearm_rdata", host_rdata, 24'h00CAFE);
    host_req = 1'b0;
    step();

    // random pix_en, host holding req a random time after ack or abandoning
    hold = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      pix_en = 1'($urandom_range(1));
      step();
      if (host_req) begin
        if (host_ack) hold = $urandom_range(3);
        if (hold == 0) begin host_req = 1'b0; hold = -1; end
        else if (hold > 0) hold--;
        else if ($urandom_range(15) == 0) host_req = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        host_req = 1'b1; host_addr = 24'($urandom);
      end
    end
    host_req = 1'b0;
    repeat (3) step();

    // async reset while the host FSM is in DATA
    pix_en = 1'b0;
    host_req = 1'b1; host_addr = 24'h0ABCDE;
    step();
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_in_data");
    host_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_ack", host_ack, 1'b0);
    rst = 1'b0;
    cyc++;
    model_reset();
    pix_en = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (host_ack) n++;
      if (i == 1) chk("restart_fs", frame_start, 1'b1);
    end
    chk("rst_no_ack", n, 0);
    repeat (FRAME) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
